// File: rtl/seconds_scan_counter_pkg.sv
// Shared constants and types for the seconds scan counter and its BCD digit cells.
package seconds_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SLOT_W = 2;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [NUM_DIGITS-1:0] DIGIT_RESET = 4'b1110;

  typedef logic [3:0] bcd_t;

  // Active-low one-cold enable for a display slot.
  function automatic logic [NUM_DIGITS-1:0] digit_en(input logic [SLOT_W-1:0] slot);
    return ~(NUM_DIGITS'(1) << slot);
  endfunction
endpackage

// File: rtl/seconds_scan_counter_bcd_digit.sv
// One mod-10 BCD digit. o_nxt is the value the digit takes on the coming edge,
// so the display can show a new count in the same cycle the digit updates.
module bcd_digit
  import seconds_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_cin,
  output bcd_t o_nxt,
  output logic o_cout
);
  bcd_t r_q;
  bcd_t w_nxt;

  always_comb begin
    w_nxt = r_q;
    if (i_clr)      w_nxt = '0;
    else if (i_cin) w_nxt = (r_q == 4'd9) ? 4'd0 : r_q + 4'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= '0;
    else       r_q <= w_nxt;
  end

  assign o_nxt  = w_nxt;
  assign o_cout = i_cin && (r_q == 4'd9);
endmodule

// File: rtl/seconds_scan_counter.sv
// 1 s prescaler, four-digit BCD seconds count and multiplexed digit scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros (digit 0 is never blanked).
module seconds_scan_counter
  import seconds_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RUN,
  input  logic                  CLR,
  output logic [3:0]            D,
  output logic [NUM_DIGITS-1:0] DIGIT,
  output logic                  TICK
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]     r_pre;
  logic [SW-1:0]     r_scan;
  logic [SLOT_W-1:0] r_slot;

  logic                  w_pre_tc;
  logic                  w_inc;
  logic                  w_scan_tc;
  logic [SLOT_W-1:0]     w_slot_nxt;
  logic [NUM_DIGITS:0]   w_carry;
  bcd_t                  w_nxt [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_blank;
  bcd_t                  w_d_nxt;
  logic                  w_unused_cout;

  assign w_pre_tc   = (r_pre == PW'(TICK_DIV - 1));
  assign w_inc      = RUN && !CLR && w_pre_tc;
  assign w_scan_tc  = (r_scan == SW'(SCAN_DIV - 1));
  assign w_slot_nxt = w_scan_tc ? r_slot + SLOT_W'(1) : r_slot;

  assign w_carry[0] = w_inc;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_clr  (CLR),
      .i_cin  (w_carry[g]),
      .o_nxt  (w_nxt[g]),
      .o_cout (w_carry[g+1])
    );
  end
  // Carry out of the top digit is dropped: 9999 wraps to 0000.
  assign w_unused_cout = w_carry[NUM_DIGITS];

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic v_lz;
    v_lz    = 1'b1;
    w_blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      v_lz       = v_lz && (w_nxt[k] == 4'd0);
      w_blank[k] = v_lz;
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_d_nxt = w_blank[w_slot_nxt] ? BLANK_CODE : w_nxt[w_slot_nxt];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pre  <= '0;
      r_scan <= '0;
      r_slot <= '0;
      DIGIT  <= DIGIT_RESET;
      D      <= 4'h0;
      TICK   <= 1'b0;
    end else begin
      if (CLR)      r_pre <= '0;
      else if (RUN) r_pre <= w_pre_tc ? '0 : r_pre + PW'(1);
      r_scan <= w_scan_tc ? '0 : r_scan + SW'(1);
      r_slot <= w_slot_nxt;
      // Slot, digit enables and digit code all move on the same edge.
      DIGIT  <= digit_en(w_slot_nxt);
      D      <= w_d_nxt;
      TICK   <= w_inc;
    end
  end
endmodule

// File: tb/tb_seconds_scan_counter.sv
// Bench for seconds_scan_counter: two instances (TICK_DIV=4 and TICK_DIV=1, SCAN_DIV=2)
// checked every cycle against an arithmetic model, plus a vector table and corner sequences.
module tb_seconds_scan_counter;
  localparam int TD = 4;
  localparam int SD = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, run = 1'b0, clr = 1'b0;
  logic [3:0] d_a, dig_a, d_b, dig_b;
  logic tick_a, tick_b;

  always #5 clk = ~clk;

  seconds_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut_a (
    .CLK(clk), .RST(rst), .RUN(run), .CLR(clr), .D(d_a), .DIGIT(dig_a), .TICK(tick_a));
  seconds_scan_counter #(.TICK_DIV(1), .SCAN_DIV(SD)) dut_b (
    .CLK(clk), .RST(rst), .RUN(run), .CLR(clr), .D(d_b), .DIGIT(dig_b), .TICK(tick_b));

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int pre;
    int cnt;
    int scan;
    int slot;
    bit tick;
  } mdl_t;
  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, int td, bit r, bit rn, bit c);
    mdl_t n;
    n = m;
    if (r) begin
      n.pre = 0; n.cnt = 0; n.scan = 0; n.slot = 0; n.tick = 0;
      return n;
    end
    n.tick = rn && !c && (m.pre == td - 1);
    if (c) begin
      n.pre = 0;
      n.cnt = 0;
    end else if (rn) begin
      n.pre = (m.pre + 1) % td;
      if (n.tick) n.cnt = (m.cnt + 1) % 10000;
    end
    n.scan = m.scan + 1;
    if (n.scan == SD) begin
      n.scan = 0;
      n.slot = (m.slot + 1) % 4;
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_dig(int slot);
    return 4'(15 - (1 << slot));
  endfunction

  function automatic logic [3:0] exp_d(int cnt, int slot);
    int p;
    p = 1;
    repeat (slot) p *= 10;
    if (BLANK && slot > 0 && cnt < p) return 4'hF;
    return 4'((cnt / p) % 10);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit rn, bit c);
    rst = r; run = rn; clr = c;
    @(posedge clk);
    ma = mstep(ma, TD, r, rn, c);
    mb = mstep(mb, 1, r, rn, c);
    #1;
    chk("a.DIGIT", dig_a, exp_dig(ma.slot));
    chk("a.D", d_a, exp_d(ma.cnt, ma.slot));
    chk("a.TICK", tick_a, ma.tick);
    chk("b.DIGIT", dig_b, exp_dig(mb.slot));
    chk("b.D", d_b, exp_d(mb.cnt, mb.slot));
    chk("b.TICK", tick_b, mb.tick);
  endtask

  // Hold RUN=0 across one full scan and collect the code shown in each slot.
  task automatic capture(bit which, output logic [15:0] dvp, output int val);
    logic [3:0] dg, dd;
    int p;
    dvp = 16'h5555;
    repeat (4 * SD) begin
      step(0, 0, 0);
      dg = which ? dig_b : dig_a;
      dd = which ? d_b : d_a;
      for (int s = 0; s < 4; s++)
        if (dg == 4'(15 - (1 << s))) dvp[4*s +: 4] = dd;
    end
    val = 0;
    p = 1;
    for (int s = 0; s < 4; s++) begin
      val += ((dvp[4*s +: 4] == 4'hF) ? 0 : int'(dvp[4*s +: 4])) * p;
      p *= 10;
    end
  endtask

  typedef struct {
    bit rst, run, clr;
    logic [3:0] digit, d, d_bl;
    bit tick;
  } vec_t;
  vec_t tv[12];

  initial begin
    logic [15:0] dvp;
    int val, ticks, last, frozen;
    int occ[4];
    logic [3:0] sd_exp[4];

    tv[0]  = '{1'b1, 1'b1, 1'b0, 4'b1110, 4'h0, 4'h0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 4'b1110, 4'h0, 4'h0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 4'b1110, 4'h0, 4'h0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 4'b1101, 4'h0, 4'hF, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 4'b1101, 4'h0, 4'hF, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 4'b1011, 4'h0, 4'hF, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 4'b1011, 4'h0, 4'hF, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 4'b0111, 4'h0, 4'hF, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 4'b0111, 4'h0, 4'hF, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 4'b1110, 4'h2, 4'h2, 1'b1};
    tv[10] = '{1'b0, 1'b1, 1'b0, 4'b1110, 4'h2, 4'h2, 1'b0};
    tv[11] = '{1'b0, 1'b1, 1'b0, 4'b1101, 4'h0, 4'hF, 1'b0};

    // Reset with RUN high, then the first ten counting edges.
    for (int i = 0; i < 12; i++) begin
      step(tv[i].rst, tv[i].run, tv[i].clr);
      chk("tbl_digit", dig_a, tv[i].digit);
      chk("tbl_d", d_a, BLANK ? tv[i].d_bl : tv[i].d);
      chk("tbl_tick", tick_a, tv[i].tick);
    end

    // Counting: 48 RUN edges after reset give 12 evenly spaced ticks.
    ticks = 2;
    last = 8;
    for (int e = 11; e <= 48; e++) begin
      step(0, 1, 0);
      if (tick_a) begin
        chk("tick_spacing", e - last, 4);
        last = e;
        ticks++;
      end
    end
    chk("tick_count_48", ticks, 12);
    frozen = 0;
    repeat (20) begin
      step(0, 0, 0);
      if (tick_a) frozen++;
    end
    chk("tick_frozen", frozen, 0);
    capture(0, dvp, val);
    chk("count_0012", val, 12);

    // CLR on the edge the prescaler would wrap, at count 0005.
    step(1, 0, 0); step(1, 0, 0);
    repeat (23) step(0, 1, 0);
    step(0, 1, 1);
    chk("clr_tick", tick_a, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0);
      chk("clr_next_tick", tick_a, (k == 3));
    end
    capture(0, dvp, val);
    chk("clr_count", val, 1);

    // Wrap on the TICK_DIV=1 instance.
    step(1, 0, 0); step(1, 0, 0);
    repeat (9999) step(0, 1, 0);
    capture(1, dvp, val);
    chk("wrap_9999", val, 9999);
    step(0, 1, 0);
    chk("wrap_tick", tick_b, 1);
    capture(1, dvp, val);
    chk("wrap_zero", val, 0);

    // Scan order and alignment at count 1234.
    step(1, 0, 0); step(1, 0, 0);
    repeat (1234) step(0, 1, 0);
    sd_exp[0] = 4'd4; sd_exp[1] = 4'd3; sd_exp[2] = 4'd2; sd_exp[3] = 4'd1;
    for (int s = 0; s < 4; s++) occ[s] = 0;
    repeat (4 * SD) begin
      step(0, 0, 0);
      for (int s = 0; s < 4; s++)
        if (dig_b == 4'(15 - (1 << s))) begin
          occ[s]++;
          chk("scan_d_align", d_b, sd_exp[s]);
        end
    end
    for (int s = 0; s < 4; s++) chk("scan_hold", occ[s], SD);

    // Leading-zero handling at 0000 and 0042.
    step(1, 0, 0); step(1, 0, 0);
    capture(1, dvp, val);
    chk("blank_0000", dvp, BLANK ? 16'hFFF0 : 16'h0000);
    repeat (42) step(0, 1, 0);
    capture(1, dvp, val);
    chk("blank_0042", dvp, BLANK ? 16'hFF42 : 16'h0042);

    // Random RUN / CLR / occasional RST against the model.
    repeat (3000)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
